// File: rtl/reflet_int_source.sv
// Interrupt request source: timer (ch0), edge-detected events (ch1-3) and software triggers
// latched into PENDING and gated by ENABLE. Optional macro REFLET_INT_SOURCE_SYNC_EN adds event synchronizers.
module reflet_int_source #(
    parameter int wordsize = 16,
    parameter int prescale = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    input  logic [2:0]          event_in,
    output logic [3:0]          irq
);

    localparam int            PW      = (prescale > 1) ? $clog2(prescale) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(prescale - 1);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } timer_state_t;

    timer_state_t        r_state;
    logic                r_oneshot;
    logic [wordsize-1:0] r_reload;
    logic [wordsize-1:0] r_count;
    logic [PW-1:0]       r_presc;
    logic [3:0]          r_pending;
    logic [3:0]          r_enable;
    logic [2:0]          r_ev_q;

    logic                w_wr_pending;
    logic                w_wr_enable;
    logic                w_wr_reload;
    logic                w_wr_control;
    logic                w_wr_trigger;
    logic                w_tick;
    logic                w_expire;
    logic [2:0]          w_ev;
    logic [2:0]          w_rise;
    logic [3:0]          w_set;
    logic [3:0]          w_clr;

    assign w_wr_pending = write_en && (addr == 3'd0);
    assign w_wr_enable  = write_en && (addr == 3'd1);
    assign w_wr_reload  = write_en && (addr == 3'd2);
    assign w_wr_control = write_en && (addr == 3'd4);
    assign w_wr_trigger = write_en && (addr == 3'd5);

`ifdef REFLET_INT_SOURCE_SYNC_EN
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= event_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ev = r_sync2;
`else
    assign w_ev = event_in;
`endif

    // A level held high produces exactly one rise, so PENDING is set once per edge.
    assign w_rise   = w_ev & ~r_ev_q;
    assign w_tick   = (r_state == RUNNING) && (r_presc == PS_LAST);
    assign w_expire = w_tick && (r_count == '0);
    assign w_set    = {w_rise, w_expire} | (w_wr_trigger ? data_in[3:0] : 4'b0000);
    assign w_clr    = w_wr_pending ? data_in[3:0] : 4'b0000;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ev_q    <= '0;
            r_pending <= '0;
            r_enable  <= '0;
        end else begin
            r_ev_q    <= w_ev;
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_wr_enable) begin
                r_enable <= data_in[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (r_state != RUNNING || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= STOPPED;
            r_oneshot <= 1'b0;
            r_reload  <= '0;
            r_count   <= '0;
        end else begin
            if (w_wr_reload) begin
                r_reload <= data_in;
            end
            case (r_state)
                STOPPED: begin
                    if (w_wr_reload) begin
                        r_count <= data_in;
                    end
                end
                RUNNING: begin
                    if (w_expire) begin
                        r_count <= r_reload;
                        if (r_oneshot) begin
                            r_state <= STOPPED;
                        end
                    end else if (w_tick) begin
                        r_count <= r_count - wordsize'(1);
                    end
                end
                default: r_state <= STOPPED;
            endcase
            // Placed last so a CONTROL write overrides a same-cycle one-shot stop.
            if (w_wr_control) begin
                r_state   <= timer_state_t'(data_in[0]);
                r_oneshot <= data_in[1];
            end
        end
    end

    // NOTE: data_out gets a default before the case so no latch is inferred.
    always_comb begin
        data_out = '0;
        case (addr)
            3'd0: data_out[3:0] = r_pending;
            3'd1: data_out[3:0] = r_enable;
            3'd2: data_out      = r_reload;
            3'd3: data_out      = r_count;
            3'd4: data_out[1:0] = {r_oneshot, (r_state == RUNNING)};
            default: data_out   = '0;
        endcase
    end

    assign irq = r_pending & r_enable;

endmodule
